bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, BRAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 32, BRAM word width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock shared with the BRAM port.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a burst read.
REQ-007 base_addr  in  ADDR_W  first BRAM address of the burst, sampled with start.
REQ-008 length  in  ADDR_W+1  word count (0..32), sampled with start.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse at burst completion.
REQ-011 bram_en  out  1  BRAM port enable (ena).
REQ-012 bram_we  out  1  BRAM write enable; constant 0.
REQ-013 bram_addr  out  ADDR_W  BRAM address.
REQ-014 bram_din  out  DATA_W  BRAM write data; constant 0.
REQ-015 bram_dout  in  DATA_W  BRAM read data; valid 1 cycle after the enabled address edge.
REQ-016 m_data, m_valid, m_last  out  DATA_W/1/1  output stream: word, valid, final-word flag.
REQ-017 m_ready  in  1  downstream accept; a transfer occurs when m_valid and m_ready are both 1 on a rising edge.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; start is accepted only in IDLE.
REQ-019 In IDLE, start=1 with length>0 SHALL latch base_addr/length, go RUN, and set busy=1 the next cycle.
REQ-020 start=1 with length=0 SHALL issue no BRAM reads and SHALL pulse done exactly one cycle later; busy stays 0.
REQ-021 start while busy SHALL be ignored, with no effect on the burst in progress.
REQ-022 The first read SHALL present bram_en=1, bram_addr=base_addr in the cycle after start (C1); read data SHALL be captured at the end of C2 and m_valid SHALL rise in C3.
REQ-023 Successive reads SHALL use bram_addr = previous+1 modulo 2^ADDR_W (31 wraps to 0).
REQ-024 Read data SHALL be buffered in a 4-entry FIFO; a read SHALL be issued only when FIFO occupancy plus in-flight reads is less than 4, so no word is ever lost under backpressure.
REQ-025 bram_en SHALL be 0 in any cycle without an issued read.
REQ-026 With m_ready held at 1, the block SHALL sustain one word per cycle after the first.
REQ-027 m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 m_last SHALL be 1 only with the length-th word.
REQ-029 After the length-th read is issued, the FSM SHALL go DRAIN; on the m_last transfer it SHALL go IDLE, pulse done in the next cycle, and clear busy in that same cycle.
REQ-030 Words SHALL be delivered in address-issue order, exactly length words per burst.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set FSM=IDLE, flush the FIFO and in-flight count, and drive busy, done, bram_en, m_valid, m_last=0 and bram_addr, m_data=0.
REQ-032 rst asserted mid-burst SHALL abort the burst with no done pulse; data returned by the BRAM after reset SHALL be discarded.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification
REQ-034 BRAM model preloaded with addr0=FFFFFFFF and addr n=n (n=1..19); start base=0 len=20, m_ready=1 -> 20 words FFFFFFFF,1..19 on consecutive cycles from C3, m_last on word 20, one done pulse, bram_we=0 throughout.
REQ-035 Same burst with m_ready toggling 1,0,0,1 repeating -> identical data sequence, no drops or duplicates, stable outputs while stalled, never more than 4 reads outstanding.
REQ-036 base=30 len=4 -> bram_addr sequence 30,31,0,1; m_last on the 4th word.
REQ-037 len=0 -> no bram_en, done one cycle after start, busy stays 0; start pulsed again mid-burst -> ignored.
REQ-038 rst asserted for 1 cycle after 5 words of a 20-word burst -> all outputs at reset values next cycle, no done pulse; a fresh start base=2 len=3 then yields 2,3,4 correctly.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Burst reader: streams `length` consecutive words from a synchronous BRAM port
// into a valid/ready output stream through a 4-entry buffer that absorbs backpressure.
module bram_stream_reader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [ADDR_W:0]   ONE_LEN  = 1;
    localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_en;
    logic                r_rd_vld;
    logic [ADDR_W:0]     r_remain;
    logic [ADDR_W:0]     r_out_remain;
    logic                r_done;
    logic [DATA_W-1:0]   r_mem [4];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_count;

    logic                w_valid;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_space;
    logic                w_accept;
    logic                w_issue;

    assign w_valid     = (r_count != 3'd0);
    assign w_xfer      = w_valid && m_ready;
    assign w_last_xfer = w_xfer && (r_out_remain == ONE_LEN);
    // Buffered words plus reads still in the BRAM pipeline must leave room for one more.
    assign w_space     = (r_count + {2'b00, r_en} + {2'b00, r_rd_vld}) < 3'd4;
    assign w_accept    = start && (r_state == S_IDLE);

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (length != '0)) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_remain == '0) w_next = S_DRAIN;
                else if (w_space)   w_issue = 1'b1;
            end
            S_DRAIN: begin
                if (w_last_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_en         <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_remain     <= '0;
            r_out_remain <= '0;
            r_done       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state  <= w_next;
            r_done   <= (w_accept && (length == '0)) || ((r_state == S_DRAIN) && w_last_xfer);
            r_rd_vld <= r_en;

            if (w_accept && (length != '0)) begin
                r_en         <= 1'b1;
                r_addr       <= base_addr;
                r_remain     <= length - ONE_LEN;
                r_out_remain <= length;
            end else if (w_issue) begin
                r_en     <= 1'b1;
                r_addr   <= r_addr + ONE_ADDR;
                r_remain <= r_remain - ONE_LEN;
            end else begin
                r_en <= 1'b0;
            end

            if (w_xfer) begin
                r_out_remain <= r_out_remain - ONE_LEN;
                r_rd_ptr     <= r_rd_ptr + 2'd1;
            end

            if (r_rd_vld) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end

            case ({r_rd_vld, w_xfer})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage is not reset; output gating keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (!rst && r_rd_vld) begin
            r_mem[r_wr_ptr] <= bram_dout;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign bram_en   = r_en;
    assign bram_we   = 1'b0;
    assign bram_addr = r_addr;
    assign bram_din  = '0;
    assign m_valid   = w_valid;
    assign m_data    = w_valid ? r_mem[r_rd_ptr] : '0;
    assign m_last    = w_valid && (r_out_remain == ONE_LEN);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural synchronous BRAM
// preloaded as addr0=FFFFFFFF, addr n=n.
module tb_bram_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic        bram_en;
    logic        bram_we;
    logic [4:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];

    bram_stream_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [4:0] a);
        return (a == 5'd0) ? 32'hFFFF_FFFF : {27'd0, a};
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},   {63'd0, busy},    64'd0);
        chk({tag, "_done"},   {63'd0, done},    64'd0);
        chk({tag, "_en"},     {63'd0, bram_en}, 64'd0);
        chk({tag, "_valid"},  {63'd0, m_valid}, 64'd0);
        chk({tag, "_last"},   {63'd0, m_last},  64'd0);
        chk({tag, "_addr"},   {59'd0, bram_addr}, 64'd0);
        chk({tag, "_mdata"},  {32'd0, m_data},  64'd0);
    endtask

    // mode 0: m_ready=1; mode 1: m_ready 1,0,0,1 repeating.
    // abort_after >= 0 returns right after that many words are accepted.
    task automatic run_burst(input logic [4:0] base, input logic [5:0] len, input int mode,
                             input int abort_after, input int inject_c);
        int          issued;
        int          accepted;
        int          last_c;
        int          budget;
        bit          last_done;
        bit          finished;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [4:0]  ea;
        issued = 0; accepted = 0; finished = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        last_done = (len == 6'd0);
        last_c = 0;
        budget = int'(len) * 4 + 20;

        @(negedge clk);
        start = 1'b1; base_addr = base; length = len;
        m_ready = ready_for(mode, 0);

        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == inject_c);
            if (c == inject_c) begin
                base_addr = 5'd7; length = 6'd2;
            end
            m_ready = ready_for(mode, c);

            chk("we",   {63'd0, bram_we}, 64'd0);
            chk("din",  {32'd0, bram_din}, 64'd0);
            chk("busy", {63'd0, busy}, {63'd0, (len != 6'd0) && !last_done});
            chk("done", {63'd0, done}, {63'd0, last_done && (c == last_c + 1)});

            if (bram_en) begin
                ea = base + issued[4:0];
                chk("issue_in_range", {63'd0, issued < int'(len)}, 64'd1);
                chk("addr", {59'd0, bram_addr}, {59'd0, ea});
                issued++;
            end
            chk("outstanding_le4", {63'd0, (issued - accepted) <= 4}, 64'd1);

            if (mode == 0 && len != 6'd0)
                chk("valid_timing", {63'd0, m_valid}, {63'd0, (c >= 3) && (c < 3 + int'(len))});

            if (prev_stall) begin
                chk("stall_valid", {63'd0, m_valid}, 64'd1);
                chk("stall_data",  {32'd0, m_data}, {32'd0, prev_data});
                chk("stall_last",  {63'd0, m_last}, {63'd0, prev_last});
            end

            if (m_valid && m_ready) begin
                ea = base + accepted[4:0];
                chk("no_extra", {63'd0, accepted < int'(len)}, 64'd1);
                chk("data", {32'd0, m_data}, {32'd0, exp_word(ea)});
                chk("last", {63'd0, m_last}, {63'd0, accepted == int'(len) - 1});
                accepted++;
                if (accepted == int'(len)) begin
                    last_done = 1'b1;
                    last_c = c;
                end
                if (accepted == abort_after) return;
            end

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;

            if (last_done && c == last_c + 2) begin
                finished = 1'b1;
                break;
            end
        end
        chk("burst_complete", {63'd0, finished}, 64'd1);
        chk("word_count", accepted, {58'd0, len});
    endtask

    initial begin
        for (int n = 0; n < 32; n++) mem[n] = (n == 0) ? 32'hFFFF_FFFF : n;
        bram_dout = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;

        repeat (2) @(negedge clk);
        start = 1'b1; length = 6'd4;
        @(negedge clk);
        check_idle_outputs("reset");
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_burst(5'd0, 6'd20, 0, -1, -1);
        run_burst(5'd0, 6'd20, 1, -1, -1);
        run_burst(5'd30, 6'd4, 0, -1, -1);
        run_burst(5'd0, 6'd0, 0, -1, -1);
        run_burst(5'd3, 6'd8, 1, -1, 5);

        run_burst(5'd0, 6'd20, 0, 5, -1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("abort");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_idle_outputs("abort_quiet");
        end

        run_burst(5'd2, 6'd3, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
